// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS-subset control FSM with IF/IW/ID/EX/ST/LD/RDW/WB sequencing
//
// Purpose: sequences fetch, decode, execute, memory and write-back for
//          ADDIU, LW, SW, BNE and SLL; any other opcode retires as a NOP from ID.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   opcode[5:0]               IR[31:26], sampled and latched in ID
//   alu_zero                  ALU zero flag, used by BNE in EX
//   inst_req_valid/ready      instruction fetch request handshake
//   inst_valid                instruction word present (IW)
//   mem_req_ready             data memory accepted LW/SW request
//   rdata_valid               LW read data present (RDW)
//   pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
//   reg_dst, alu_src          datapath enables/selects
//   alu_op[11:0]              one-hot ALU select: bit0 add, bit1 sub, bit8 sll
//   write_strb[3:0]           constant 4'b1111
//   state[3:0]                current FSM state code
// Configuration macro CTRL_PERF_CNT_EN adds cycle_cnt[31:0] and inst_cnt[31:0].

module multi_cycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        alu_zero,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    input  logic        inst_valid,
    input  logic        mem_req_ready,
    input  logic        rdata_valid,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        alu_src,
    output logic [11:0] alu_op,
`ifdef CTRL_PERF_CNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] inst_cnt,
`endif
    output logic [3:0]  write_strb,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_INIT = 4'd0,
        S_IF   = 4'd1,
        S_IW   = 4'd2,
        S_ID   = 4'd3,
        S_EX   = 4'd4,
        S_ST   = 4'd5,
        S_LD   = 4'd6,
        S_RDW  = 4'd7,
        S_WB   = 4'd8
    } state_t;

    localparam logic [5:0]  OP_SLL   = 6'b000000;
    localparam logic [5:0]  OP_BNE   = 6'b000101;
    localparam logic [5:0]  OP_ADDIU = 6'b001001;
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;

    localparam logic [11:0] ALU_ADD  = 12'h001;
    localparam logic [11:0] ALU_SUB  = 12'h002;
    localparam logic [11:0] ALU_SLL  = 12'h100;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        inst_req_valid = 1'b0;
        pc_write       = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_to_reg     = 1'b0;
        reg_dst        = 1'b0;
        alu_src        = 1'b0;
        alu_op         = 12'd0;
        retire         = 1'b0;
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                inst_req_valid = 1'b1;
                if (inst_req_ready) state_d = S_IW;
            end
            S_IW: begin
                // Instruction capture and PC+4 happen in the cycle the word arrives.
                if (inst_valid) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    alu_op   = ALU_ADD;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                op_d = opcode;
                case (opcode)
                    OP_ADDIU, OP_LW, OP_SW, OP_BNE, OP_SLL: state_d = S_EX;
                    default: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                endcase
            end
            S_EX: begin
                case (op_q)
                    OP_ADDIU: begin alu_op = ALU_ADD; alu_src = 1'b1; state_d = S_WB; end
                    OP_LW:    begin alu_op = ALU_ADD; alu_src = 1'b1; state_d = S_LD; end
                    OP_SW:    begin alu_op = ALU_ADD; alu_src = 1'b1; state_d = S_ST; end
                    OP_SLL:   begin alu_op = ALU_SLL; alu_src = 1'b1; state_d = S_WB; end
                    OP_BNE: begin
                        alu_op   = ALU_SUB;
                        pc_write = ~alu_zero;
                        state_d  = S_IF;
                        retire   = 1'b1;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_ST: begin
                mem_write = 1'b1;
                alu_op    = ALU_ADD;
                if (mem_req_ready) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end
            end
            S_LD: begin
                mem_read = 1'b1;
                alu_op   = ALU_ADD;
                if (mem_req_ready) state_d = S_RDW;
            end
            S_RDW: begin
                if (rdata_valid) state_d = S_WB;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
                reg_dst    = (op_q == OP_ADDIU) || (op_q == OP_LW);
                state_d    = S_IF;
                retire     = 1'b1;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign write_strb = 4'b1111;
    assign state      = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] inst_cnt_q, inst_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        inst_cnt_d  = inst_cnt_q + {31'd0, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= 32'd0;
            inst_cnt_q  <= 32'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign inst_cnt  = inst_cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl

module tb_multi_cycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        alu_zero;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic        inst_valid;
    logic        mem_req_ready;
    logic        rdata_valid;
    logic        pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg;
    logic        reg_dst, alu_src;
    logic [11:0] alu_op;
    logic [3:0]  write_strb;
    logic [3:0]  state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, inst_cnt;
    logic [31:0] cnt_snap;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .alu_zero       (alu_zero),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_valid     (inst_valid),
        .mem_req_ready  (mem_req_ready),
        .rdata_valid    (rdata_valid),
        .pc_write       (pc_write),
        .ir_write       (ir_write),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .reg_dst        (reg_dst),
        .alu_src        (alu_src),
        .alu_op         (alu_op),
`ifdef CTRL_PERF_CNT_EN
        .cycle_cnt      (cycle_cnt),
        .inst_cnt       (inst_cnt),
`endif
        .write_strb     (write_strb),
        .state          (state)
    );

    // {pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src, inst_req_valid}
    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_IF    = 9'b000000001;
    localparam logic [8:0] O_IW    = 9'b110000000;
    localparam logic [8:0] O_EXI   = 9'b000000010;
    localparam logic [8:0] O_WB_AD = 9'b001000100;
    localparam logic [8:0] O_WB_LW = 9'b001001100;
    localparam logic [8:0] O_WB_SL = 9'b001000000;
    localparam logic [8:0] O_ST    = 9'b000010000;
    localparam logic [8:0] O_LD    = 9'b000100000;
    localparam logic [8:0] O_BNE_T = 9'b100000000;

    function automatic logic [8:0] outs();
        return {pc_write, ir_write, reg_write, mem_read, mem_write, mem_to_reg,
                reg_dst, alu_src, inst_req_valid};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IF with zero-wait fetch, walk IF->IW->ID->EX checking each step.
    task automatic run_to_ex(input logic [5:0] op);
        opcode         = op;
        inst_req_ready = 1'b1;
        inst_valid     = 1'b1;
        check("if_state", 32'(state), 32'd1);
        check("if_outs", 32'(outs()), 32'(O_IF));
        tick();
        check("iw_state", 32'(state), 32'd2);
        check("iw_outs", 32'(outs()), 32'(O_IW));
        check("iw_alu", 32'(alu_op), 32'h001);
        tick();
        check("id_state", 32'(state), 32'd3);
        check("id_outs", 32'(outs()), 32'(O_NONE));
        tick();
        check("ex_state", 32'(state), 32'd4);
    endtask

    initial begin
        rst = 1'b1; opcode = 6'd0; alu_zero = 1'b0;
        inst_req_ready = 1'b0; inst_valid = 1'b0;
        mem_req_ready = 1'b0; rdata_valid = 1'b0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'(outs()), 32'(O_NONE));
        check("rst_alu", 32'(alu_op), 32'd0);
        check("rst_strb", 32'(write_strb), 32'hF);
`ifdef CTRL_PERF_CNT_EN
        check("rst_cyc", cycle_cnt, 32'd0);
        check("rst_inst", inst_cnt, 32'd0);
`endif
        rst = 1'b0;
        tick();
        check("init_to_if", 32'(state), 32'd1);

        // IF holds without ready; IW holds without inst_valid and enables stay low
        tick();
        check("if_hold", 32'(state), 32'd1);
        inst_req_ready = 1'b1;
        tick();
        inst_req_ready = 1'b0;
        check("iw_hold_outs", 32'(outs()), 32'(O_NONE));
        tick();
        check("iw_hold_state", 32'(state), 32'd2);
        inst_valid = 1'b1; opcode = 6'b001001;
        tick();
        tick();
        tick();
        tick();
        check("iwhold_seq_if", 32'(state), 32'd1);

        // ADDIU zero-wait: 1,2,3,4,8,1
        mem_req_ready = 1'b1; rdata_valid = 1'b1;
        run_to_ex(6'b001001);
        check("addiu_ex_outs", 32'(outs()), 32'(O_EXI));
        check("addiu_ex_alu", 32'(alu_op), 32'h001);
        tick();
        check("addiu_wb_state", 32'(state), 32'd8);
        check("addiu_wb_outs", 32'(outs()), 32'(O_WB_AD));
        tick();
        check("addiu_ret_if", 32'(state), 32'd1);
        check("addiu_if_outs", 32'(outs()), 32'(O_IF));

        // SLL
        run_to_ex(6'b000000);
        check("sll_ex_outs", 32'(outs()), 32'(O_EXI));
        check("sll_ex_alu", 32'(alu_op), 32'h100);
        tick();
        check("sll_wb_outs", 32'(outs()), 32'(O_WB_SL));
        tick();

        // SW with zero-wait
        run_to_ex(6'b101011);
        check("sw_ex_alu", 32'(alu_op), 32'h001);
        tick();
        check("sw_st_state", 32'(state), 32'd5);
        check("sw_st_outs", 32'(outs()), 32'(O_ST));
        check("sw_st_alu", 32'(alu_op), 32'h001);
        tick();
        check("sw_ret_if", 32'(state), 32'd1);

        // LW: mem_req_ready low 3 cycles, rdata_valid low 2 cycles
        run_to_ex(6'b100011);
        mem_req_ready = 1'b0; rdata_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("lw_ld_state", 32'(state), 32'd6);
            check("lw_ld_outs", 32'(outs()), 32'(O_LD));
            mem_req_ready = (i == 3);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("lw_rdw_state", 32'(state), 32'd7);
            check("lw_rdw_outs", 32'(outs()), 32'(O_NONE));
            rdata_valid = (j == 2);
            tick();
        end
        check("lw_wb_state", 32'(state), 32'd8);
        check("lw_wb_outs", 32'(outs()), 32'(O_WB_LW));
        tick();
        check("lw_ret_if", 32'(state), 32'd1);
        mem_req_ready = 1'b1; rdata_valid = 1'b1;

        // BNE taken then not taken
        alu_zero = 1'b0;
        run_to_ex(6'b000101);
        check("bne_t_outs", 32'(outs()), 32'(O_BNE_T));
        check("bne_t_alu", 32'(alu_op), 32'h002);
        tick();
        check("bne_t_if", 32'(state), 32'd1);
        alu_zero = 1'b1;
        run_to_ex(6'b000101);
        check("bne_n_outs", 32'(outs()), 32'(O_NONE));
        check("bne_n_alu", 32'(alu_op), 32'h002);
        tick();
        check("bne_n_if", 32'(state), 32'd1);

        // NOP opcode 111111: ID -> IF
`ifdef CTRL_PERF_CNT_EN
        cnt_snap = inst_cnt;
`endif
        opcode = 6'b111111;
        tick();
        tick();
        check("nop_id_state", 32'(state), 32'd3);
        check("nop_id_outs", 32'(outs()), 32'(O_NONE));
        tick();
        check("nop_if", 32'(state), 32'd1);
`ifdef CTRL_PERF_CNT_EN
        check("nop_inst_cnt", inst_cnt, cnt_snap + 32'd1);
`endif

        // Reset pulsed during LD
        run_to_ex(6'b100011);
        mem_req_ready = 1'b0;
        tick();
        check("rld_state", 32'(state), 32'd6);
        check("rld_memread", 32'(mem_read), 32'd1);
        rst = 1'b1;
        tick();
        check("rld_rst_state", 32'(state), 32'd0);
        check("rld_rst_outs", 32'(outs()), 32'(O_NONE));
        check("rld_rst_alu", 32'(alu_op), 32'd0);
        rst = 1'b0;
        tick();
        check("rld_if", 32'(state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
